// File: rtl/pzcorebus_pkg.sv
// Shared types and helpers for the pzcorebus request switch.
//
// Contents:
//   pzcorebus_switch_state_e : data-ordering state of the request switch scheduler
//   pzcorebus_rr_search      : cyclic first-one search starting at a pointer
package pzcorebus_pkg;

   localparam int PZCOREBUS_MAX_SLAVES = 16;

   typedef enum logic [1:0] {
      IDLE,
      CMD_DONE,
      DATA_DONE
   } pzcorebus_switch_state_e;

   // Returns {found, index} of the first set bit of request at or after
   // pointer, wrapping at slaves. Only the low slaves bits are considered.
   function automatic logic [4:0] pzcorebus_rr_search(
      input logic [PZCOREBUS_MAX_SLAVES-1:0] request,
      input int                              pointer,
      input int                              slaves
   );
      logic [4:0] result;
      logic [3:0] index;
      result = '0;
      index  = '0;
      for (int i = 0; i < PZCOREBUS_MAX_SLAVES; i++) begin
         if (i < slaves) begin
            index = 4'((pointer + i) % slaves);
            if (request[index] && !result[4]) begin
               result = {1'b1, index};
            end
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/pzcorebus_outstanding_counter.sv
// Outstanding non-posted command counter for a single requester.
//
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   up             : one non-posted command accepted
//   down           : final response for one command delivered
//   count          : commands awaiting a response
//   full           : registered, count has reached MAX_OUTSTANDING
module pzcorebus_outstanding_counter #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int COUNT_WIDTH     = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   up,
   input  logic                   down,
   output logic [COUNT_WIDTH-1:0] count,
   output logic                   full
);

   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = COUNT_WIDTH'(MAX_OUTSTANDING);

   logic [COUNT_WIDTH-1:0] count_next;

   // A same-cycle up and down cancel; saturate at both ends.
   always_comb begin
      count_next = count;
      if (up && !down && (count != COUNT_MAX)) begin
         count_next = count + COUNT_WIDTH'(1);
      end else if (down && !up && (count != '0)) begin
         count_next = count - COUNT_WIDTH'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count <= '0;
         full  <= 1'b0;
      end else begin
         count <= count_next;
         full  <= (count_next == COUNT_MAX);
      end
   end

`ifndef SYNTHESIS
   a_no_underflow : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      !(down && !up && (count == '0)));
   a_no_overflow : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      !(up && !down && (count == COUNT_MAX)));
`endif

endmodule

// File: rtl/pzcorebus_request_switch_scheduler.sv
// Command/data arbitration and sequencing for an m-to-1 corebus request switch.
//
// Ports:
//   i_clk, i_rst_n     : clock, asynchronous active-low reset
//   i_request          : command valid per requester
//   i_non_posted       : command of requester i expects a response
//   i_with_data        : command of requester i carries write data
//   o_command_grant    : one-hot command select
//   i_command_ack      : command accepted on the master side
//   i_data_last_ack    : last write-data beat accepted on the master side
//   o_data_grant       : one-hot write-data select
//   i_response_ack     : final response beat of one outstanding command
//   i_response_select  : one-hot owner of that response
//   o_outstanding_full : requester i has MAX_OUTSTANDING commands in flight
//   o_busy             : grant held, data pending or any command outstanding
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// IDLE      | command and its write data travel together, data follows grant
// CMD_DONE  | with-data command accepted, its data still flowing; only
//           | no-data commands may be granted meanwhile
// DATA_DONE | write data finished before its command; command grant pinned
//           | to the data owner until that command is accepted
module pzcorebus_request_switch_scheduler
   import pzcorebus_pkg::*;
#(
   parameter int SLAVES          = 4,
   parameter int WEIGHT          = 1,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [SLAVES-1:0] i_request,
   input  logic [SLAVES-1:0] i_non_posted,
   input  logic [SLAVES-1:0] i_with_data,
   output logic [SLAVES-1:0] o_command_grant,
   input  logic              i_command_ack,
   input  logic              i_data_last_ack,
   output logic [SLAVES-1:0] o_data_grant,
   input  logic              i_response_ack,
   input  logic [SLAVES-1:0] i_response_select,
   output logic [SLAVES-1:0] o_outstanding_full,
   output logic              o_busy
);

   localparam int COUNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
   localparam int PTR_W       = $clog2(SLAVES);

   pzcorebus_switch_state_e state;
   logic [SLAVES-1:0]       held_grant;
   logic                    locked;
   logic [SLAVES-1:0]       locked_grant;
   logic [PTR_W-1:0]        pointer;
   logic [2:0]              weight_count;

   logic [SLAVES-1:0] eligible;
   logic [4:0]        search;
   logic [SLAVES-1:0] arb_grant;
   logic [PTR_W-1:0]  grant_index;
   logic [PTR_W-1:0]  next_pointer;
   logic [2:0]        run_count;
   logic              weight_hit;
   logic [SLAVES-1:0] count_nonzero;

   always_comb begin
      eligible = i_request & ~(i_non_posted & o_outstanding_full);
      if (state == CMD_DONE) begin
         eligible = eligible & ~i_with_data;
      end
      search    = pzcorebus_rr_search(16'(eligible), int'(pointer), SLAVES);
      arb_grant = search[4] ? (SLAVES'(1) << search[3:0]) : '0;
   end

   always_comb begin
      case (state)
         DATA_DONE: o_command_grant = held_grant;
         default:   o_command_grant = locked ? locked_grant : arb_grant;
      endcase
      case (state)
         IDLE:     o_data_grant = o_command_grant;
         CMD_DONE: o_data_grant = held_grant;
         default:  o_data_grant = '0;
      endcase
   end

   // Weighted round-robin: a grant away from the pointer starts a fresh run.
   always_comb begin
      grant_index = '0;
      for (int i = 0; i < SLAVES; i++) begin
         if (o_command_grant[i]) grant_index = PTR_W'(i);
      end
      run_count    = (grant_index == pointer) ? weight_count : 3'd0;
      weight_hit   = (int'(run_count) == WEIGHT - 1);
      next_pointer = (int'(grant_index) == SLAVES - 1) ? '0 : grant_index + PTR_W'(1);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pointer      <= '0;
         weight_count <= '0;
         locked       <= 1'b0;
         locked_grant <= '0;
      end else if (i_command_ack) begin
         locked <= 1'b0;
         if (weight_hit) begin
            pointer      <= next_pointer;
            weight_count <= 3'd0;
         end else begin
            pointer      <= grant_index;
            weight_count <= run_count + 3'd1;
         end
      end else if (|o_command_grant) begin
         locked       <= 1'b1;
         locked_grant <= o_command_grant;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         held_grant <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_command_ack && |(o_command_grant & i_with_data) && !i_data_last_ack) begin
                  state      <= CMD_DONE;
                  held_grant <= o_command_grant;
               end else if (i_data_last_ack && !i_command_ack) begin
                  state      <= DATA_DONE;
                  held_grant <= o_command_grant;
               end
            end
            CMD_DONE:  if (i_data_last_ack) state <= IDLE;
            DATA_DONE: if (i_command_ack) state <= IDLE;
            default:   state <= IDLE;
         endcase
      end
   end

   for (genvar i = 0; i < SLAVES; i++) begin : g_counter
      logic [COUNT_WIDTH-1:0] count;
      pzcorebus_outstanding_counter #(
         .MAX_OUTSTANDING (MAX_OUTSTANDING),
         .COUNT_WIDTH     (COUNT_WIDTH)
      ) u_counter (
         .i_clk   (i_clk),
         .i_rst_n (i_rst_n),
         .up      (i_command_ack && o_command_grant[i] && i_non_posted[i]),
         .down    (i_response_ack && i_response_select[i]),
         .count   (count),
         .full    (o_outstanding_full[i])
      );
      assign count_nonzero[i] = |count;
   end

   assign o_busy = (|o_command_grant) || (state != IDLE) || (|count_nonzero);

`ifndef SYNTHESIS
   a_command_grant_onehot : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      $onehot0(o_command_grant));
   a_data_grant_onehot : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      $onehot0(o_data_grant));
   a_command_ack_granted : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      i_command_ack |-> (|o_command_grant));
   a_data_last_ack_granted : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      i_data_last_ack |-> ((|o_data_grant) || ((state == IDLE) && |(o_command_grant & i_with_data))));
   a_response_select_onehot : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      i_response_ack |-> $onehot(i_response_select));
`endif

endmodule

// File: tb/tb_pzcorebus_request_switch_scheduler.sv
module tb_pzcorebus_request_switch_scheduler;

   typedef struct packed {
      logic [3:0] req;
      logic [3:0] np;
      logic [3:0] wd;
      logic       ack;
      logic       dla;
      logic       rack;
      logic [3:0] rsel;
      logic [3:0] cmd;
      logic [3:0] data;
      logic [3:0] full;
   } row_t;

   typedef struct packed {
      logic [3:0] cmd;
      logic [3:0] data;
      logic [3:0] full;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;

   logic [3:0] request, non_posted, with_data, response_select;
   logic       command_ack, data_last_ack, response_ack;
   logic [3:0] command_grant, data_grant, outstanding_full;
   logic       busy;

   logic [3:0] b_request, b_non_posted, b_with_data, b_response_select;
   logic       b_command_ack, b_data_last_ack, b_response_ack;
   logic [3:0] b_command_grant, b_data_grant, b_outstanding_full;
   logic       b_busy;

   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[$];
   logic [3:0] b_q[$];

   always #5 clk = ~clk;

   pzcorebus_request_switch_scheduler #(
      .SLAVES(4), .WEIGHT(1), .MAX_OUTSTANDING(2)
   ) dut_a (
      .i_clk              (clk),
      .i_rst_n            (rst_n),
      .i_request          (request),
      .i_non_posted       (non_posted),
      .i_with_data        (with_data),
      .o_command_grant    (command_grant),
      .i_command_ack      (command_ack),
      .i_data_last_ack    (data_last_ack),
      .o_data_grant       (data_grant),
      .i_response_ack     (response_ack),
      .i_response_select  (response_select),
      .o_outstanding_full (outstanding_full),
      .o_busy             (busy)
   );

   pzcorebus_request_switch_scheduler #(
      .SLAVES(4), .WEIGHT(2), .MAX_OUTSTANDING(4)
   ) dut_b (
      .i_clk              (clk),
      .i_rst_n            (rst_n),
      .i_request          (b_request),
      .i_non_posted       (b_non_posted),
      .i_with_data        (b_with_data),
      .o_command_grant    (b_command_grant),
      .i_command_ack      (b_command_ack),
      .i_data_last_ack    (b_data_last_ack),
      .o_data_grant       (b_data_grant),
      .i_response_ack     (b_response_ack),
      .i_response_select  (b_response_select),
      .o_outstanding_full (b_outstanding_full),
      .o_busy             (b_busy)
   );

   function automatic row_t mk(input logic [3:0] req, input logic [3:0] np, input logic [3:0] wd,
                               input logic ack, input logic dla, input logic rack, input logic [3:0] rsel,
                               input logic [3:0] cmd, input logic [3:0] data, input logic [3:0] full);
      row_t r;
      r.req = req; r.np = np; r.wd = wd; r.ack = ack; r.dla = dla; r.rack = rack;
      r.rsel = rsel; r.cmd = cmd; r.data = data; r.full = full;
      return r;
   endfunction

   task automatic idle_a();
      request = '0; non_posted = '0; with_data = '0; response_select = '0;
      command_ack = 1'b0; data_last_ack = 1'b0; response_ack = 1'b0;
   endtask

   task automatic drive_a(input row_t r);
      exp_t e;
      request = r.req; non_posted = r.np; with_data = r.wd;
      command_ack = r.ack; data_last_ack = r.dla;
      response_ack = r.rack; response_select = r.rsel;
      e.cmd = r.cmd; e.data = r.data; e.full = r.full;
      exp_q.push_back(e);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle_a();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle_a();
      #1;
      checks++; if (command_grant !== 4'b0000) begin errors++; $display("FAIL reset_cmd got %b want 0000", command_grant); end
      checks++; if (data_grant !== 4'b0000) begin errors++; $display("FAIL reset_data got %b want 0000", data_grant); end
      checks++; if (outstanding_full !== 4'b0000) begin errors++; $display("FAIL reset_full got %b want 0000", outstanding_full); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      checks++; if ({command_grant, data_grant, busy} !== 9'b0) begin errors++; $display("FAIL reset_release got cmd=%b data=%b busy=%b want all 0", command_grant, data_grant, busy); end
   endtask

   task automatic test_round_robin();
      row_t rows[$];
      exp_t e;
      apply_reset();
      rows.push_back(mk(4'b1111, 4'b0, 4'b0, 1, 0, 0, 4'b0, 4'b0001, 4'b0001, 4'b0));
      rows.push_back(mk(4'b1111, 4'b0, 4'b0, 1, 0, 0, 4'b0, 4'b0010, 4'b0010, 4'b0));
      rows.push_back(mk(4'b1111, 4'b0, 4'b0, 1, 0, 0, 4'b0, 4'b0100, 4'b0100, 4'b0));
      rows.push_back(mk(4'b1111, 4'b0, 4'b0, 1, 0, 0, 4'b0, 4'b1000, 4'b1000, 4'b0));
      rows.push_back(mk(4'b1111, 4'b0, 4'b0, 1, 0, 0, 4'b0, 4'b0001, 4'b0001, 4'b0));
      foreach (rows[k]) begin
         @(negedge clk);
         drive_a(rows[k]);
         #1;
         e = exp_q.pop_front();
         checks++;
         if ({command_grant, data_grant, outstanding_full} !== {e.cmd, e.data, e.full}) begin
            errors++;
            $display("FAIL round_robin cyc%0d got cmd=%b data=%b full=%b want cmd=%b data=%b full=%b",
                     k, command_grant, data_grant, outstanding_full, e.cmd, e.data, e.full);
         end
      end
      @(negedge clk);
      idle_a();
   endtask

   task automatic test_weight();
      logic [3:0] want;
      logic [3:0] seq [5] = '{4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0001};
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         b_request = 4'b0101;
         b_command_ack = 1'b1;
         b_q.push_back(seq[k]);
         #1;
         want = b_q.pop_front();
         checks++;
         if ({b_command_grant, b_data_grant} !== {want, want}) begin
            errors++;
            $display("FAIL weight cyc%0d got cmd=%b data=%b want %b", k, b_command_grant, b_data_grant, want);
         end
      end
      @(negedge clk);
      b_request = '0;
      b_command_ack = 1'b0;
   endtask

   task automatic test_cmd_done();
      row_t rows[$];
      exp_t e;
      apply_reset();
      rows.push_back(mk(4'b0010, 4'b0, 4'b0010, 1, 0, 0, 4'b0, 4'b0010, 4'b0010, 4'b0));
      rows.push_back(mk(4'b0101, 4'b0, 4'b0100, 1, 0, 0, 4'b0, 4'b0001, 4'b0010, 4'b0));
      rows.push_back(mk(4'b0100, 4'b0, 4'b0100, 0, 0, 0, 4'b0, 4'b0000, 4'b0010, 4'b0));
      rows.push_back(mk(4'b0100, 4'b0, 4'b0100, 0, 1, 0, 4'b0, 4'b0000, 4'b0010, 4'b0));
      rows.push_back(mk(4'b0100, 4'b0, 4'b0100, 1, 1, 0, 4'b0, 4'b0100, 4'b0100, 4'b0));
      foreach (rows[k]) begin
         @(negedge clk);
         drive_a(rows[k]);
         #1;
         e = exp_q.pop_front();
         checks++;
         if ({command_grant, data_grant, outstanding_full} !== {e.cmd, e.data, e.full}) begin
            errors++;
            $display("FAIL cmd_done cyc%0d got cmd=%b data=%b full=%b want cmd=%b data=%b full=%b",
                     k, command_grant, data_grant, outstanding_full, e.cmd, e.data, e.full);
         end
      end
      @(negedge clk);
      idle_a();
   endtask

   task automatic test_data_done();
      row_t rows[$];
      exp_t e;
      apply_reset();
      rows.push_back(mk(4'b1000, 4'b0, 4'b1000, 0, 1, 0, 4'b0, 4'b1000, 4'b1000, 4'b0));
      rows.push_back(mk(4'b1001, 4'b0, 4'b1000, 0, 0, 0, 4'b0, 4'b1000, 4'b0000, 4'b0));
      rows.push_back(mk(4'b1001, 4'b0, 4'b1000, 1, 0, 0, 4'b0, 4'b1000, 4'b0000, 4'b0));
      rows.push_back(mk(4'b0001, 4'b0, 4'b0000, 1, 0, 0, 4'b0, 4'b0001, 4'b0001, 4'b0));
      foreach (rows[k]) begin
         @(negedge clk);
         drive_a(rows[k]);
         #1;
         e = exp_q.pop_front();
         checks++;
         if ({command_grant, data_grant, outstanding_full} !== {e.cmd, e.data, e.full}) begin
            errors++;
            $display("FAIL data_done cyc%0d got cmd=%b data=%b full=%b want cmd=%b data=%b full=%b",
                     k, command_grant, data_grant, outstanding_full, e.cmd, e.data, e.full);
         end
      end
      @(negedge clk);
      idle_a();
   endtask

   // Ends with two commands outstanding for requester 0 so the reset test has state to clear.
   task automatic test_outstanding();
      row_t rows[$];
      exp_t e;
      apply_reset();
      rows.push_back(mk(4'b0001, 4'b0001, 4'b0, 1, 0, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0000));
      rows.push_back(mk(4'b0001, 4'b0001, 4'b0, 1, 0, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0000));
      rows.push_back(mk(4'b0001, 4'b0001, 4'b0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001));
      rows.push_back(mk(4'b0001, 4'b0001, 4'b0, 0, 0, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0001));
      rows.push_back(mk(4'b0001, 4'b0001, 4'b0, 1, 0, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0000));
      rows.push_back(mk(4'b0001, 4'b0001, 4'b0, 0, 0, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0001));
      rows.push_back(mk(4'b0001, 4'b0001, 4'b0, 1, 0, 1, 4'b0001, 4'b0001, 4'b0001, 4'b0000));
      rows.push_back(mk(4'b0001, 4'b0001, 4'b0, 1, 0, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0000));
      rows.push_back(mk(4'b0001, 4'b0001, 4'b0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001));
      foreach (rows[k]) begin
         @(negedge clk);
         drive_a(rows[k]);
         #1;
         e = exp_q.pop_front();
         checks++;
         if ({command_grant, data_grant, outstanding_full} !== {e.cmd, e.data, e.full}) begin
            errors++;
            $display("FAIL outstanding cyc%0d got cmd=%b data=%b full=%b want cmd=%b data=%b full=%b",
                     k, command_grant, data_grant, outstanding_full, e.cmd, e.data, e.full);
         end
      end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL outstanding_busy got %b want 1", busy); end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      @(negedge clk);
      rst_n = 1'b0;
      idle_a();
      #1;
      checks++;
      if ({command_grant, data_grant, outstanding_full, busy} !== 13'b0) begin
         errors++;
         $display("FAIL reset_mid got cmd=%b data=%b full=%b busy=%b want all 0",
                  command_grant, data_grant, outstanding_full, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         drive_a(mk(4'b0001, 4'b0001, 4'b0, 1, 0, 0, 4'b0, 4'b0001, 4'b0001, 4'b0000));
         #1;
         e = exp_q.pop_front();
         checks++;
         if ({command_grant, data_grant, outstanding_full} !== {e.cmd, e.data, e.full}) begin
            errors++;
            $display("FAIL reset_mid_after got cmd=%b data=%b full=%b want cmd=%b data=%b full=%b",
                     command_grant, data_grant, outstanding_full, e.cmd, e.data, e.full);
         end
      end
      @(negedge clk);
      idle_a();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      idle_a();
      b_request = '0; b_non_posted = '0; b_with_data = '0; b_response_select = '0;
      b_command_ack = 1'b0; b_data_last_ack = 1'b0; b_response_ack = 1'b0;
      test_reset();
      test_round_robin();
      test_weight();
      test_cmd_done();
      test_data_done();
      test_outstanding();
      test_reset_mid();
      checks++;
      if ({b_outstanding_full, b_busy} !== 5'b0) begin
         errors++;
         $display("FAIL weight_idle got full=%b busy=%b want 0", b_outstanding_full, b_busy);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
